// File: rtl/sync_fifo_ctrl_if.sv
// Request/status bundle between a FIFO requester and the sync_fifo_ctrl pointer controller.
// The memory write-data path is not part of this bundle; the requester drives the RAM directly.
interface sync_fifo_ctrl_if #(
    parameter int A_SIZE = 4
);
    logic              push;
    logic              pop;
    logic              clr_err;
    logic              wen;
    logic [A_SIZE-1:0] waddr;
    logic [A_SIZE-1:0] raddr;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [A_SIZE:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, clr_err,
        input  wen, waddr, raddr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err,
        output wen, waddr, raddr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO pointer controller for an external RAM with combinational read.
// Flags and count come only from the registered pointers; sticky over/underflow errors.
module sync_fifo_ctrl #(
    parameter int A_SIZE   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input logic             wclk,
    input logic             wrst,
    sync_fifo_ctrl_if.slave bus
);
    localparam int              PW     = A_SIZE + 1;
    localparam logic [A_SIZE:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [A_SIZE:0] AE_THR = PW'(AE_LEVEL);
    localparam logic [A_SIZE:0] ONE    = PW'(1);

    logic [A_SIZE:0] r_wptr;
    logic [A_SIZE:0] r_rptr;
    logic            r_overflow;
    logic            r_underflow;

    logic [A_SIZE:0] w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic            w_ovf_set;
    logic            w_unf_set;

    always_comb begin
        w_count   = r_wptr - r_rptr;
        w_empty   = (r_wptr == r_rptr);
        w_full    = (r_wptr[A_SIZE] != r_rptr[A_SIZE]) &&
                    (r_wptr[A_SIZE-1:0] == r_rptr[A_SIZE-1:0]);
        // wen must stay low for the whole reset, even with push held high
        w_push_ok = bus.push & ~w_full & ~wrst;
        w_pop_ok  = bus.pop & ~w_empty;
        w_ovf_set = bus.push & w_full;
        w_unf_set = bus.pop & w_empty;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + ONE;
            if (w_pop_ok)  r_rptr <= r_rptr + ONE;
            // a same-edge error event takes priority over clr_err
            r_overflow  <= w_ovf_set | (r_overflow  & ~bus.clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~bus.clr_err);
        end
    end

    assign bus.wen          = w_push_ok;
    assign bus.waddr        = r_wptr[A_SIZE-1:0];
    assign bus.raddr        = r_rptr[A_SIZE-1:0];
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = w_count;
    assign bus.almost_full  = (w_count >= AF_THR);
    assign bus.almost_empty = (w_count <= AE_THR);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed, table-driven bench for sync_fifo_ctrl with a 16x8 RAM model on its ports.
module tb_sync_fifo_ctrl;
    localparam int A_SIZE = 4;
    localparam int DEPTH  = 16;

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] wdata;
        logic       exp_wen;
        logic [3:0] exp_waddr;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic [4:0] exp_count;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] mem [DEPTH];
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[$];

    sync_fifo_ctrl_if #(.A_SIZE(A_SIZE)) bus ();

    sync_fifo_ctrl #(
        .A_SIZE  (A_SIZE),
        .AF_LEVEL(12),
        .AE_LEVEL(4)
    ) dut (
        .wclk(clk),
        .wrst(rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.wen) mem[bus.waddr] <= wdata;
    assign rdata = mem[bus.raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags are fully determined by the occupancy for AF_LEVEL=12, AE_LEVEL=4, DEPTH=16
    task automatic chk_state(input string tag, input logic [4:0] cnt,
                             input logic ovf, input logic unf);
        chk($sformatf("%s count", tag), 32'(bus.count), 32'(cnt));
        chk($sformatf("%s full", tag), 32'(bus.full), 32'(cnt == 5'd16));
        chk($sformatf("%s empty", tag), 32'(bus.empty), 32'(cnt == 5'd0));
        chk($sformatf("%s almost_full", tag), 32'(bus.almost_full), 32'(cnt >= 5'd12));
        chk($sformatf("%s almost_empty", tag), 32'(bus.almost_empty), 32'(cnt <= 5'd4));
        chk($sformatf("%s overflow", tag), 32'(bus.overflow), 32'(ovf));
        chk($sformatf("%s underflow", tag), 32'(bus.underflow), 32'(unf));
    endtask

    function automatic vec_t mk(input logic push, input logic pop, input logic clr,
                                input logic [7:0] wd, input logic wen, input logic [3:0] wa,
                                input logic chk_rd, input logic [7:0] rd,
                                input logic [4:0] cnt, input logic ovf, input logic unf);
        vec_t v;
        v.push = push; v.pop = pop; v.clr = clr; v.wdata = wd;
        v.exp_wen = wen; v.exp_waddr = wa; v.chk_rd = chk_rd; v.exp_rd = rd;
        v.exp_count = cnt; v.exp_ovf = ovf; v.exp_unf = unf;
        return v;
    endfunction

    // Entered just after a rising edge: drive, check request-side outputs mid-cycle, check state after the edge
    task automatic apply(input vec_t v, input string tag);
        bus.push    = v.push;
        bus.pop     = v.pop;
        bus.clr_err = v.clr;
        wdata       = v.wdata;
        @(negedge clk);
        chk($sformatf("%s wen", tag), 32'(bus.wen), 32'(v.exp_wen));
        chk($sformatf("%s waddr", tag), 32'(bus.waddr), 32'(v.exp_waddr));
        if (v.chk_rd) chk($sformatf("%s rdata", tag), 32'(rdata), 32'(v.exp_rd));
        @(posedge clk);
        #1;
        chk_state(tag, v.exp_count, v.exp_ovf, v.exp_unf);
    endtask

    initial begin
        // Fill: 16 pushes, overflow attempt, clear, 16 pops, underflow with set-beats-clear
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 0, 8'(i), 1, 4'(i), 0, 8'h00, 5'(i + 1), 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'hEE, 0, 4'd0, 0, 8'h00, 5'd16, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 4'd0, 0, 8'h00, 5'd16, 0, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 1, 0, 8'h00, 0, 4'd0, 1, 8'(i), 5'(15 - i), 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 4'd0, 0, 8'h00, 5'd0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 0, 4'd0, 0, 8'h00, 5'd0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 4'd0, 0, 8'h00, 5'd0, 0, 0));

        // Reset with push held high: wen must stay low
        rst = 1'b1; bus.push = 1'b1; bus.pop = 1'b0; bus.clr_err = 1'b0; wdata = 8'h00;
        #3;
        chk("reset wen", 32'(bus.wen), 32'd0);
        chk_state("reset", 5'd0, 0, 0);
        @(posedge clk);
        #1;
        chk("reset edge wen", 32'(bus.wen), 32'd0);
        chk_state("reset edge", 5'd0, 0, 0);
        rst = 1'b0; bus.push = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));
        chk("after underflow raddr", 32'(bus.raddr), 32'd0);

        // Streaming at count=3 across the pointer wrap
        for (int j = 0; j < 3; j++)
            apply(mk(1, 0, 0, 8'(8'hA0 + j), 1, 4'(j), 0, 8'h00, 5'(j + 1), 0, 0),
                  $sformatf("stream_fill%0d", j));
        for (int k = 0; k < 40; k++)
            apply(mk(1, 1, 0, 8'(8'hA3 + k), 1, 4'((3 + k) % 16), 1, 8'(8'hA0 + k), 5'd3, 0, 0),
                  $sformatf("stream%0d", k));
        for (int j = 0; j < 3; j++)
            apply(mk(0, 1, 0, 8'h00, 0, 4'd11, 1, 8'(8'hC8 + j), 5'(2 - j), 0, 0),
                  $sformatf("stream_drain%0d", j));

        // Push+pop while empty, then while full
        apply(mk(1, 1, 0, 8'h55, 1, 4'd11, 0, 8'h00, 5'd1, 0, 1), "empty_pp");
        apply(mk(0, 0, 1, 8'h00, 0, 4'd12, 1, 8'h55, 5'd1, 0, 0), "empty_pp_read");
        for (int j = 0; j < 15; j++)
            apply(mk(1, 0, 0, 8'(8'h60 + j), 1, 4'((12 + j) % 16), 0, 8'h00, 5'(2 + j), 0, 0),
                  $sformatf("refill%0d", j));
        apply(mk(1, 1, 0, 8'h77, 0, 4'd11, 1, 8'h55, 5'd15, 1, 0), "full_pp");
        apply(mk(0, 0, 1, 8'h00, 0, 4'd11, 1, 8'h60, 5'd15, 0, 0), "full_pp_clr");

        // Asynchronous reset mid-cycle with 7 entries held
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 7; j++)
            apply(mk(1, 0, 0, 8'(8'h10 + j), 1, 4'(j), 0, 8'h00, 5'(j + 1), 0, 0),
                  $sformatf("pre_rst%0d", j));
        bus.push = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst wen", 32'(bus.wen), 32'd0);
        chk_state("mid_rst", 5'd0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk(1, 0, 0, 8'h99, 1, 4'd0, 0, 8'h00, 5'd1, 0, 0), "post_rst_push");
        apply(mk(0, 1, 0, 8'h00, 0, 4'd1, 1, 8'h99, 5'd0, 0, 0), "post_rst_pop");

        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter A_SIZE, default 4, giving memory address width; DEPTH = 2^A_SIZE entries.
REQ-002 The block SHALL have parameter AF_LEVEL, default 12, the almost-full threshold in entries (1..DEPTH-1).
REQ-003 The block SHALL have parameter AE_LEVEL, default 4, the almost-empty threshold in entries (1..DEPTH-1).
REQ-004 wclk  input  1  sole clock; all state changes on its rising edge.
REQ-005 wrst  input  1  reset, asynchronous, active-high.
REQ-006 push  input  1  write request; the data word is presented by the requester directly on the memory wdata port.
REQ-007 pop  input  1  read request; consume the word currently on memory rdata.
REQ-008 clr_err  input  1  clears sticky error flags.
REQ-009 wen  output  1  memory write enable.
REQ-010 waddr  output  A_SIZE  memory write address.
REQ-011 raddr  output  A_SIZE  memory read address (memory read is combinational).
REQ-012 full, empty  output  1 each  occupancy flags.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  A_SIZE+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write pointer wptr and read pointer rptr SHALL be A_SIZE+1 bits; waddr = wptr[A_SIZE-1:0], raddr = rptr[A_SIZE-1:0].
REQ-017 Pointers SHALL wrap modulo 2^(A_SIZE+1); count = wptr - rptr modulo 2^(A_SIZE+1).
REQ-018 empty SHALL be 1 iff wptr == rptr; full SHALL be 1 iff the MSBs differ and the low A_SIZE bits are equal.
REQ-019 almost_full SHALL be 1 iff count >= AF_LEVEL; almost_empty SHALL be 1 iff count <= AE_LEVEL.
REQ-020 All flags and count SHALL derive only from registered pointers, never from same-cycle push/pop.
REQ-021 A push SHALL be accepted iff push=1 and full=0; wen SHALL equal that acceptance combinationally.
REQ-022 An accepted push SHALL write at waddr on the same edge and increment wptr by 1.
REQ-023 A pop SHALL be accepted iff pop=1 and empty=0; an accepted pop SHALL increment rptr by 1 at the edge.
REQ-024 While empty=0, memory rdata at raddr SHALL be the oldest word (zero-latency show-ahead).
REQ-025 Simultaneous accepted push and pop SHALL leave count unchanged and move both pointers.
REQ-026 When full, push+pop SHALL accept only the pop; count becomes DEPTH-1.
REQ-027 When empty, push+pop SHALL accept only the push; count becomes 1, and data is readable the next cycle.
REQ-028 overflow SHALL set on any edge with push=1 and full=1; underflow SHALL set on any edge with pop=1 and empty=1.
REQ-029 clr_err=1 SHALL clear both error flags at the edge, except that a same-cycle set SHALL win over the clear.
REQ-030 Rejected requests SHALL not change the pointers or memory.

Reset
REQ-031 wrst=1 SHALL immediately, without a clock, force wptr=0, rptr=0, overflow=0, underflow=0, giving empty=1, full=0, count=0, almost_empty=1, almost_full=0, wen=0.
REQ-032 Reset asserted mid-operation SHALL discard all contents; memory is not cleared but becomes unreachable.
REQ-033 wen SHALL be 0 throughout reset regardless of push.

Verification
REQ-034 Reset, then 16 pushes with data 0x00..0x0F -> waddr 0..15, full=1 after 16th edge, count=16, almost_full set after 12th push, almost_empty cleared after 5th push.
REQ-035 From full, push=1 one cycle -> wen=0, overflow=1, count=16; then clr_err -> overflow=0.
REQ-036 From full, 16 pops -> rdata sequence 0x00..0x0F, empty=1 after last, then pop -> underflow=1, rptr unchanged.
REQ-037 Continuous push+pop for 40 cycles starting with count=3 -> count stays 3, pointers wrap past 31 to 0, data order preserved.
REQ-038 Empty with push+pop same cycle -> count=1, underflow=1, next-cycle rdata equals pushed word; full with push+pop -> count=15, overflow=1.
REQ-039 Assert wrst asynchronously mid-cycle with count=7 -> empty=1, count=0 before the next wclk edge; push afterwards writes waddr=0.
